// File: rtl/ita_hwpe_stream_scheduler_if.sv
// ita_hwpe_stream_scheduler_if: job trigger, streamer/engine handshakes and status of the job scheduler
interface ita_hwpe_stream_scheduler_if #(parameter int CNT_W = 32);
  logic             start_i;
  logic             clear_i;
  logic [4:0]       ctrl_stream_i;
  logic             in_ready_start_i;
  logic             wt_ready_start_i;
  logic             bias_ready_start_i;
  logic             out_ready_start_i;
  logic             in_done_i;
  logic             wt_done_i;
  logic             bias_done_i;
  logic             out_done_i;
  logic             in_start_o;
  logic             wt_start_o;
  logic             bias_start_o;
  logic             out_start_o;
  logic             engine_start_o;
  logic             engine_done_i;
  logic             bias_direction_o;
  logic             busy_o;
  logic             evt_done_o;
  logic             preloaded_o;
  logic [CNT_W-1:0] run_cycles_o;
  modport master (
    input  start_i, clear_i, ctrl_stream_i,
    input  in_ready_start_i, wt_ready_start_i, bias_ready_start_i, out_ready_start_i,
    input  in_done_i, wt_done_i, bias_done_i, out_done_i, engine_done_i,
    output in_start_o, wt_start_o, bias_start_o, out_start_o, engine_start_o,
    output bias_direction_o, busy_o, evt_done_o, preloaded_o, run_cycles_o
  );
  modport slave (
    output start_i, clear_i, ctrl_stream_i,
    output in_ready_start_i, wt_ready_start_i, bias_ready_start_i, out_ready_start_i,
    output in_done_i, wt_done_i, bias_done_i, out_done_i, engine_done_i,
    input  in_start_o, wt_start_o, bias_start_o, out_start_o, engine_start_o,
    input  bias_direction_o, busy_o, evt_done_o, preloaded_o, run_cycles_o
  );
endinterface

// File: rtl/ita_hwpe_stream_scheduler.sv
// ita_hwpe_stream_scheduler: per-job sequencer launching ITA streamers and engine, tracking completion
module ita_hwpe_stream_scheduler #(
  parameter int CNT_W = 32
) (
  input logic clk_i,
  input logic rst_i,
  ita_hwpe_stream_scheduler_if.master bus
);
  typedef enum logic [2:0] {IDLE, PRELOAD, LAUNCH, RUN, NEXTLOAD, DONE} state_t;
  // unit bit order everywhere: {engine, out, bias, wt, in}
  state_t           state_q;
  logic [4:1]       cfg_q;
  logic [4:0]       pend_q, started_q, done_q;
  logic             preloaded_q, ph_q;
  logic [CNT_W-1:0] run_q;
  logic [4:0]       rdy, dn, fire;
  logic             in_ph, ph_fire, ph_done;
  function automatic logic [4:0] pend_mask(input logic out_dis, input logic bias_dis, input logic pre);
    return {1'b1, ~out_dis, ~bias_dis, ~pre, 1'b1};
  endfunction
  // start pulses are gated by ready in the same cycle; weight phase fires once per PRELOAD/NEXTLOAD
  always_comb begin
    rdy     = {1'b1, bus.out_ready_start_i, bus.bias_ready_start_i, bus.wt_ready_start_i, bus.in_ready_start_i};
    dn      = {bus.engine_done_i, bus.out_done_i, bus.bias_done_i, bus.wt_done_i, bus.in_done_i};
    fire    = state_q == LAUNCH ? pend_q & rdy : '0;
    in_ph   = state_q == PRELOAD || state_q == NEXTLOAD;
    ph_fire = in_ph && !ph_q && bus.wt_ready_start_i;
    ph_done = in_ph && bus.wt_done_i && (ph_q || ph_fire);
  end
  assign bus.in_start_o       = fire[0];
  assign bus.wt_start_o       = fire[1] | ph_fire;
  assign bus.bias_start_o     = fire[2];
  assign bus.out_start_o      = fire[3];
  assign bus.engine_start_o   = fire[4];
  assign bus.bias_direction_o = cfg_q[3];
  assign bus.busy_o           = state_q != IDLE;
  assign bus.evt_done_o       = state_q == DONE;
  assign bus.preloaded_o      = preloaded_q;
  assign bus.run_cycles_o     = run_q;
  // job sequencing; clear_i aborts exactly like reset
  always_ff @(posedge clk_i) begin
    if (rst_i || bus.clear_i) begin
      state_q     <= IDLE;
      cfg_q       <= '0;
      pend_q      <= '0;
      started_q   <= '0;
      done_q      <= '0;
      preloaded_q <= 1'b0;
      ph_q        <= 1'b0;
      run_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.start_i) begin
          cfg_q     <= bus.ctrl_stream_i[4:1];
          run_q     <= '0;
          ph_q      <= 1'b0;
          started_q <= '0;
          done_q    <= '0;
          pend_q    <= pend_mask(bus.ctrl_stream_i[4], bus.ctrl_stream_i[2], preloaded_q);
          state_q   <= bus.ctrl_stream_i[0] && !preloaded_q ? PRELOAD : LAUNCH;
        end
        PRELOAD: begin
          ph_q <= ph_q | ph_fire;
          if (ph_done) begin
            preloaded_q <= 1'b1;
            pend_q      <= pend_mask(cfg_q[4], cfg_q[2], 1'b1);
            state_q     <= LAUNCH;
          end
        end
        LAUNCH: begin
          pend_q    <= pend_q & ~fire;
          started_q <= started_q | fire;
          done_q    <= done_q | (dn & (started_q | fire));
          if ((pend_q & ~fire) == '0) begin
            preloaded_q <= 1'b0;
            state_q     <= RUN;
          end
        end
        RUN: begin
          done_q <= done_q | (dn & started_q);
          run_q  <= &run_q ? run_q : run_q + CNT_W'(1);
          if ((done_q & started_q) == started_q) begin
            ph_q    <= 1'b0;
            state_q <= cfg_q[1] ? NEXTLOAD : DONE;
          end
        end
        NEXTLOAD: begin
          ph_q <= ph_q | ph_fire;
          if (ph_done) begin
            preloaded_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
